// File: rtl/matmul_seq_ctrl.sv
// Sequencer for a DIM x DIM C = A*B pass: walks i/j/k loops, drives operand/result addresses and MAC strobes.
// Optional cycle counter output is enabled by defining MATMUL_CYC_CNT_EN.
module matmul_seq_ctrl #(
  parameter  int DIM = 3,
  localparam int AW  = $clog2(DIM * DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW-1:0] addr_c,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          c_we,
  output logic          busy,
  output logic          done
`ifdef MATMUL_CYC_CNT_EN
  ,
  output logic [15:0]   cyc_cnt
`endif
);

  localparam int            CW   = (DIM > 2) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic [CW-1:0] k_q, k_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [AW-1:0] addr_c_q, addr_c_d;
  logic          mac_clr_q, mac_clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] row, input logic [CW-1:0] col);
    return AW'(DIM) * AW'(row) + AW'(col);
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (!hold) begin
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = WRITE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (!hold) begin
          state_d = RUN;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs follow the next state; addresses only move while the pass is active.
  always_comb begin
    busy_d    = (state_d == RUN) || (state_d == WRITE);
    done_d    = (state_d == DONE);
    mac_clr_d = (state_d == RUN) && (k_d == '0);
    addr_a_d  = addr_a_q;
    addr_b_d  = addr_b_q;
    addr_c_d  = addr_c_q;
    if (busy_d) begin
      addr_a_d = addr_of(i_d, k_d);
      addr_b_d = addr_of(k_d, j_d);
      addr_c_d = addr_of(i_d, j_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      addr_c_q  <= '0;
      mac_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      addr_c_q  <= addr_c_d;
      mac_clr_q <= mac_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Strobes must drop in the same cycle hold rises, so they gate the registered state with hold.
  assign mac_en  = (state_q == RUN) && !hold;
  assign c_we    = (state_q == WRITE) && !hold;
  assign addr_a  = addr_a_q;
  assign addr_b  = addr_b_q;
  assign addr_c  = addr_c_q;
  assign mac_clr = mac_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef MATMUL_CYC_CNT_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if ((state_q == IDLE) && start) begin
      cyc_cnt_d = '0;
    end else if (((state_q == RUN) || (state_q == WRITE)) && (cyc_cnt_q != 16'hFFFF)) begin
      cyc_cnt_d = cyc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized self-checking bench for matmul_seq_ctrl (DIM=3) against a step-list model of one C = A*B pass.
module tb_matmul_seq_ctrl;

  localparam int DIM   = 3;
  localparam int AW    = $clog2(DIM * DIM);
  localparam int NSTEP = DIM * DIM * (DIM + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic          hold;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-1:0] addr_c;
  logic          mac_clr;
  logic          mac_en;
  logic          c_we;
  logic          busy;
  logic          done;
`ifdef MATMUL_CYC_CNT_EN
  logic [15:0]   cyc_cnt;
`endif

  int checkCount = 0;
  int errCount   = 0;

  typedef struct {
    bit wr;
    int k;
    int a;
    int b;
    int c;
  } step_t;

  step_t steps[$];

  matmul_seq_ctrl #(.DIM(DIM)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .hold   (hold),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .addr_c (addr_c),
    .mac_clr(mac_clr),
    .mac_en (mac_en),
    .c_we   (c_we),
    .busy   (busy),
    .done   (done)
`ifdef MATMUL_CYC_CNT_EN
    ,
    .cyc_cnt(cyc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    checkCount++;
    if (got !== expVal) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expVal);
    end
  endtask

  // One pass in program order: DIM products per element, then its write.
  task automatic buildModel();
    step_t s;
    steps.delete();
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        for (int k = 0; k < DIM; k++) begin
          s.wr = 1'b0; s.k = k; s.a = DIM * i + k; s.b = DIM * k + j; s.c = DIM * i + j;
          steps.push_back(s);
        end
        s.wr = 1'b1; s.k = 0; s.a = DIM * i; s.b = j; s.c = DIM * i + j;
        steps.push_back(s);
      end
    end
  endtask

  function automatic logic [31:0] outVec();
    return {15'd0, addr_a, addr_b, addr_c, mac_clr, mac_en, c_we, busy, done};
  endfunction

  // holdMode: 0 none, 1 random, 2 five cycles at k=1 of the first element
  task automatic applyStimulus(input int holdMode, output int busyCycles);
    int    p;
    int    holdLeft;
    int    macCount;
    int    weCount;
    int    budget;
    int    holdCount;
    bit    h;
    bit    doneSeen;
    step_t s;

    @(negedge clk);
    start = 1'b1;
    hold  = 1'($urandom_range(0, 1));
    #1;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    @(posedge clk);

    p = 0; holdLeft = (holdMode == 2) ? 5 : 0; busyCycles = 0;
    macCount = 0; weCount = 0; budget = 0; doneSeen = 0; holdCount = 0;
    while (!doneSeen && budget < 400) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      if (p < NSTEP) begin
        s = steps[p];
        case (holdMode)
          1:       h = ($urandom_range(0, 3) == 0);
          2:       h = (p == 1) && (holdLeft > 0);
          default: h = 1'b0;
        endcase
      end else begin
        h = 1'($urandom_range(0, 1));
      end
      hold = h;
      #1;
      if (busy) busyCycles++;
      if (p < NSTEP) begin
        checkOutput("busy", busy, 1);
        checkOutput("done_early", done, 0);
        checkOutput("addr_c", addr_c, s.c);
        if (!s.wr) begin
          checkOutput("addr_a", addr_a, s.a);
          checkOutput("addr_b", addr_b, s.b);
        end
        checkOutput("mac_clr", mac_clr, 32'(!s.wr && s.k == 0));
        checkOutput("mac_en", mac_en, 32'(!s.wr && !h));
        checkOutput("c_we", c_we, 32'(s.wr && !h));
        if (mac_en) macCount++;
        if (c_we) weCount++;
        if (h) begin
          holdCount++;
          if (holdMode == 2) holdLeft--;
        end else begin
          p++;
        end
      end else begin
        checkOutput("done", done, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_mac_en", mac_en, 0);
        checkOutput("done_c_we", c_we, 0);
        checkOutput("done_addr_c", addr_c, DIM * DIM - 1);
        doneSeen = 1'b1;
      end
      budget++;
    end
    checkOutput("done_seen", 32'(doneSeen), 1);
    checkOutput("mac_count", macCount, DIM * DIM * DIM);
    checkOutput("we_count", weCount, DIM * DIM);
    checkOutput("busy_cycles", busyCycles, NSTEP + holdCount);

    @(negedge clk);
    start = 1'b0;
    hold  = 1'($urandom_range(0, 1));
    #1;
    checkOutput("post_busy", busy, 0);
    checkOutput("post_done", done, 0);
    checkOutput("post_addr_c", addr_c, DIM * DIM - 1);
`ifdef MATMUL_CYC_CNT_EN
    checkOutput("cyc_cnt", cyc_cnt, NSTEP + holdCount);
`endif
  endtask

  initial begin
    int b;
    buildModel();
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_outputs", outVec(), 0);
`ifdef MATMUL_CYC_CNT_EN
    checkOutput("reset_cyc_cnt", cyc_cnt, 0);
`endif
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      hold = 1'($urandom_range(0, 1));
      #1;
      checkOutput("idle_stays", busy, 0);
    end

    $display("[TB] no-hold pass");
    applyStimulus(0, b);
    checkOutput("pass_len_nohold", b, NSTEP);
    $display("[TB] five-cycle hold at k=1");
    applyStimulus(2, b);
    checkOutput("pass_len_hold5", b, NSTEP + 5);
    $display("[TB] random hold passes");
    applyStimulus(1, b);
    applyStimulus(1, b);

    $display("[TB] reset mid-pass");
    @(negedge clk);
    start = 1'b1; hold = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    checkOutput("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_outputs", outVec(), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      checkOutput("no_done_after_reset", {30'd0, busy, done}, 0);
    end
    applyStimulus(0, b);
    checkOutput("pass_len_after_reset", b, NSTEP);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
